trng_bit_packer: RTL and testbench
==================================

# trng_bit_packer

Downstream consumer of the icestick TRNG's Fibonacci LFSR / raw entropy bit stream. Takes one raw bit per valid strobe, optionally removes bias with a von Neumann extractor, and packs the surviving bits LSB-first into WIDTH-bit words. Words are buffered in a small first-word-fall-through FIFO with a valid/ready output handshake, so the LED driver or a future UART stage can drain them. Overruns are counted, not stalled: the entropy source has no backpressure.

## Interface
- `WIDTH`, 5: bits per output word. Default matches LEDs D1–D5. Legal range 2..32.
- `DEPTH`, 4: FIFO entries. Power of two, 2..16.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bit_in`  in  1  raw entropy bit.
- `bit_valid`  in  1  `bit_in` is sampled on edges where this is high.
- `word_out`  out  WIDTH  FIFO head word.
- `word_valid`  out  1  FIFO non-empty.
- `word_ready`  in  1  consumer accepts `word_out` on edges where valid and ready are both high.
- `fill_level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a completed word is dropped.
- `drop_count`  out  8  dropped-word count; saturates at 255.

## Operation
- Reset values: all outputs 0, including `word_out`. The pair flag, bit counter, shift register and FIFO pointers are cleared. Reset mid-operation discards any partial pair, any partial word and all buffered words.
- Stage 1, extractor:
  - Holds `first` and a `have_first` flag.
  - On `bit_valid` with `have_first`=0: store `bit_in` in `first` and set `have_first`.
  - On `bit_valid` with `have_first`=1: clear `have_first`.
    - If `first`≠`bit_in`, emit `first` as a registered `vn_bit` with `vn_valid`=1 for one cycle. Pair 10 emits 1; pair 01 emits 0.
    - Equal pairs are discarded.
- Stage 2, packer:
  - On `vn_valid`: shift right with `shift <= {vn_bit, shift[WIDTH-1:1]}`. The first bit of a word ends at bit 0.
  - Counter runs 0..WIDTH-1.
  - On the WIDTH-th bit, `{vn_bit, shift[WIDTH-1:1]}` is pushed into the FIFO at that same edge and the counter wraps to 0.
- FIFO:
  - Pop on `word_valid && word_ready`.
  - Push when not full, or when full with a pop on the same edge. That case is accepted, there is no drop, and the level is unchanged.
  - Push when full without a pop: the word is discarded, `overflow` is set, and `drop_count` increments (held at 255).
  - Packing continues regardless of FIFO state.
  - Simultaneous push and pop when empty is impossible, because the FIFO is first-word-fall-through and there is no bypass.
- `overflow` and `drop_count` clear only on `reset`.

## Timing
- Latency: the raw bit that completes a word is sampled at edge N. `vn_valid` is high after N. The FIFO write happens at edge N+1, and `word_valid`/`word_out` are valid after edge N+1. That is 2 clocks.
- `fill_level` and `word_valid` update on the same edge as the push or pop.
- Throughput: one raw bit per clock. That gives at most one extracted bit per 2 clocks, or one word per 2·WIDTH clocks best case.
- `word_out` is stable while `word_valid`=1 and `word_ready`=0.

## Configuration
- Macro: `TRNG_VN_DEBIAS_EN`.
- Defined: the von Neumann extractor operates as described above.
- Undefined: stage 1 becomes a plain pipeline register. Each sampled `bit_in` appears as `vn_bit` with `vn_valid` one cycle later, and pairs are not formed.
- Latency (2 clocks) and all other behaviour are identical in both builds.

## Test plan
- Debias on, `WIDTH`=5, raw pairs 10,01,10,10,01 on consecutive clocks with `word_ready`=1 → one word, `word_out`=5'b01101 (0x0D), `word_valid` high exactly 2 clocks after the last raw bit sample.
- Debias on, 20 raw bits of 1, then 20 raw bits of 0 → `word_valid` stays 0 and `fill_level` stays 0.
- `word_ready`=0, feed enough bits for 6 words → `fill_level`=4, `overflow`=1, `drop_count`=2. Then `word_ready`=1 → the first 4 words drain in order and `fill_level` returns to 0.
- FIFO full, word completes on the same edge as a pop → no drop, `fill_level` stays 4, `drop_count` unchanged.
- Debias off: feed 3 bits, assert `reset` for 1 clock, then feed 1,1,0,0,1 → exactly one word, 5'b10011 (0x13). Every output reads 0 during the cycle after reset.
- Debias off: 255+3 dropped words → `drop_count`=255 and holds there.

Source files
------------

// File: rtl/trng_bit_packer.sv
// Raw entropy bits -> optional von Neumann debias -> LSB-first WIDTH-bit words -> FWFT FIFO.
// Define TRNG_VN_DEBIAS_EN to enable the von Neumann extractor; otherwise stage 1 is a plain register.
module trng_bit_packer #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(WIDTH);

  // Stage 1: extractor (or pass-through register)
  logic vn_bit_q, vn_bit_d, vn_valid_q, vn_valid_d;

`ifdef TRNG_VN_DEBIAS_EN
  logic first_q, first_d, have_first_q, have_first_d;

  always_comb begin
    first_d      = first_q;
    have_first_d = have_first_q;
    vn_valid_d   = 1'b0;
    vn_bit_d     = vn_bit_q;
    if (bit_valid) begin
      if (!have_first_q) begin
        first_d      = bit_in;
        have_first_d = 1'b1;
      end else begin
        have_first_d = 1'b0;
        if (first_q != bit_in) begin
          vn_valid_d = 1'b1;
          vn_bit_d   = first_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_q      <= 1'b0;
      have_first_q <= 1'b0;
    end else begin
      first_q      <= first_d;
      have_first_q <= have_first_d;
    end
  end
`else
  assign vn_valid_d = bit_valid;
  assign vn_bit_d   = bit_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      vn_bit_q   <= 1'b0;
      vn_valid_q <= 1'b0;
    end else begin
      vn_bit_q   <= vn_bit_d;
      vn_valid_q <= vn_valid_d;
    end
  end

  // Stage 2: packer. Only the upper WIDTH-1 bits are kept; bit 0 would be shifted out unused.
  logic [WIDTH-1:1] shift_q, shift_d;
  logic [WIDTH-1:0] push_word;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push;

  assign push_word = {vn_bit_q, shift_q};

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (vn_valid_q) begin
      shift_d = push_word[WIDTH-1:1];
      if (cnt_q == CntW'(WIDTH - 1)) begin
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // FIFO
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    fill_q, fill_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;
  logic             pop, full, accept, drop;

  always_comb begin
    pop        = (fill_q != '0) && word_ready;
    full       = (fill_q == (PtrW + 1)'(DEPTH));
    // A pop on a full FIFO frees the slot for a same-edge push.
    accept     = push && (!full || pop);
    drop       = push && full && !pop;
    wr_ptr_d   = wr_ptr_q + PtrW'(accept);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    fill_d     = fill_q + (PtrW + 1)'(accept) - (PtrW + 1)'(pop);
    overflow_d = overflow_q | drop;
    drop_d     = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= push_word;
  end

  assign word_valid = (fill_q != '0);
  assign word_out   = word_valid ? mem_q[rd_ptr_q] : '0;
  assign fill_level = fill_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_trng_bit_packer.sv
// Randomized and directed bench for trng_bit_packer against a queue-based reference model.
// Honors TRNG_VN_DEBIAS_EN the same way as the design.
module tb_trng_bit_packer;
  localparam int W = 5;
  localparam int D = 4;
  localparam int LvlW = $clog2(D) + 1;
  localparam int VecW = 1 + LvlW + W + 1 + 8;

  typedef logic [W-1:0] word_t;

  logic            clk = 1'b0;
  logic            reset, bit_in, bit_valid, word_ready;
  logic [W-1:0]    word_out;
  logic            word_valid;
  logic [LvlW-1:0] fill_level;
  logic            overflow;
  logic [7:0]      drop_count;

  trng_bit_packer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fill_level (fill_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: extracted bits collect in a queue; a full queue becomes a word that
  // lands in the FIFO queue one edge later.
  word_t m_fifo[$];
  bit    m_bits[$];
  bit    m_have_first, m_first, m_pend, m_ovf;
  word_t m_pend_word;
  int    m_drop;

  logic [VecW-1:0] dut_vec;
  assign dut_vec = {word_valid, fill_level, word_out, overflow, drop_count};

  function automatic logic [VecW-1:0] model_vec();
    logic [LvlW-1:0] lvl;
    word_t           head;
    lvl  = LvlW'(m_fifo.size());
    head = (m_fifo.size() != 0) ? m_fifo[0] : '0;
    return {m_fifo.size() != 0, lvl, head, m_ovf, 8'(m_drop)};
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_bits.delete();
    m_have_first = 0; m_first = 0; m_pend = 0; m_ovf = 0; m_drop = 0; m_pend_word = '0;
  endtask

  task automatic model_emit(input bit x);
    word_t w;
    m_bits.push_back(x);
    if (m_bits.size() == W) begin
      w = '0;
      for (int i = 0; i < W; i++) w[i] = m_bits[i];
      m_bits.delete();
      m_pend = 1;
      m_pend_word = w;
    end
  endtask

  task automatic model_edge(input bit v, input bit b, input bit r);
    if (r && m_fifo.size() != 0) void'(m_fifo.pop_front());
    if (m_pend) begin
      if (m_fifo.size() < D) m_fifo.push_back(m_pend_word);
      else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
      m_pend = 0;
    end
    if (v) begin
`ifdef TRNG_VN_DEBIAS_EN
      if (!m_have_first) begin
        m_first = b;
        m_have_first = 1;
      end else begin
        m_have_first = 0;
        if (m_first != b) model_emit(m_first);
      end
`else
      model_emit(b);
`endif
    end
  endtask

  task automatic step(input bit v, input bit b, input bit r);
    bit_valid = v; bit_in = b; word_ready = r;
    @(posedge clk);
    model_edge(v, b, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; bit_valid = 0; bit_in = 0; word_ready = 0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  // Raw stimulus that extracts to exactly the bits of w, LSB first.
  task automatic feed_word(input word_t w, input bit r);
    for (int i = 0; i < W; i++) begin
`ifdef TRNG_VN_DEBIAS_EN
      step(1, w[i], r);
      step(1, !w[i], r);
`else
      step(1, w[i], r);
`endif
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (dut_vec !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0", dut_vec);
    end
  endtask

  task automatic test_latency();
    do_reset();
    feed_word(5'h0D, 1);
    vectors++;
    if (word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: word_valid=%b expected 0 one clock after last bit", word_valid);
    end
    step(0, 0, 1);
    vectors++;
    if (word_valid !== 1'b1 || word_out !== 5'h0D) begin
      miscompares++;
      $display("FAIL latency_word: valid=%b word=%h expected 1/0d", word_valid, word_out);
    end
    vectors++;
    if (dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL latency_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_equal_pairs();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1, i < 20, 1);
`ifdef TRNG_VN_DEBIAS_EN
      vectors++;
      if (word_valid !== 1'b0 || fill_level !== '0) begin
        miscompares++;
        $display("FAIL equal_pairs cyc %0d: valid=%b fill=%0d expected 0/0", i, word_valid,
                 fill_level);
      end
`else
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL const_bits cyc %0d: got %h expected %h", i, dut_vec, model_vec());
      end
`endif
    end
  endtask

  task automatic test_overflow();
    word_t sent[$];
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sent.push_back(word_t'($urandom));
      feed_word(sent[k], 0);
    end
    step(0, 0, 0);
    vectors++;
    if (fill_level !== LvlW'(4) || overflow !== 1'b1 || drop_count !== 8'd2) begin
      miscompares++;
      $display("FAIL overflow_state: fill=%0d ovf=%b drops=%0d expected 4/1/2", fill_level,
               overflow, drop_count);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (word_valid !== 1'b1 || word_out !== sent[k]) begin
        miscompares++;
        $display("FAIL drain_order %0d: valid=%b word=%h expected 1/%h", k, word_valid,
                 word_out, sent[k]);
      end
      step(0, 0, 1);
    end
    vectors++;
    if (fill_level !== '0 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL drain_empty: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  // Relies on drop_count=2 and an empty FIFO left by test_overflow.
  task automatic test_pop_on_full();
    word_t sent[$];
    for (int k = 0; k < 5; k++) begin
      sent.push_back(word_t'($urandom));
      feed_word(sent[k], 0);
    end
    step(0, 0, 1);
    vectors++;
    if (fill_level !== LvlW'(4) || drop_count !== 8'd2 || word_out !== sent[1]) begin
      miscompares++;
      $display("FAIL pop_on_full: fill=%0d drops=%0d head=%h expected 4/2/%h", fill_level,
               drop_count, word_out, sent[1]);
    end
    vectors++;
    if (dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL pop_on_full_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1'($urandom), 0);
    do_reset();
    vectors++;
    if (dut_vec !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_zero: got %h expected 0", dut_vec);
    end
    feed_word(5'h13, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    vectors++;
    if (fill_level !== LvlW'(1) || word_out !== 5'h13) begin
      miscompares++;
      $display("FAIL reset_mid_word: fill=%0d word=%h expected 1/13", fill_level, word_out);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < D + 258; k++) feed_word(word_t'($urandom), 0);
    step(0, 0, 0);
    vectors++;
    if (drop_count !== 8'd255 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate: drops=%0d ovf=%b expected 255/1", drop_count, overflow);
    end
    feed_word(word_t'($urandom), 0);
    step(0, 0, 0);
    vectors++;
    if (drop_count !== 8'd255 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL saturate_hold: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3) != 0, 1'($urandom), 1'($urandom));
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    reset = 1; bit_valid = 0; bit_in = 0; word_ready = 0;
    model_reset();
    test_reset();
    test_latency();
    test_equal_pairs();
    test_overflow();
    test_pop_on_full();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
